// File: rtl/rv_pkg.sv
// Shared core definitions: opcodes, control word, ID/EX register image and operand-use helpers.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [3:0] alu_select;
    logic       reg_write_en;
    logic       bsel;
    logic       asel;
    logic       dm_write_en;
    logic [1:0] wbsel;
  } ctrl_word_t;

  localparam ctrl_word_t BUBBLE_CTRL = '0;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    ctrl_word_t      ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            valid;
  } stage_t;

  localparam stage_t BUBBLE_STAGE = '{ctrl: BUBBLE_CTRL, default: '0};

  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs, EX-side register outputs and hazard/flush controls of the ID/EX stage.
interface id_ex_stage_if;
  import rv_pkg::*;

  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic [3:0]      id_alu_select;
  logic            id_reg_write_en;
  logic            id_bsel;
  logic            id_asel;
  logic            id_dm_write_en;
  logic [1:0]      id_wbsel;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            pc_sel_ex;

  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [3:0]      ex_alu_select;
  logic            ex_reg_write_en;
  logic            ex_bsel;
  logic            ex_asel;
  logic            ex_dm_write_en;
  logic [1:0]      ex_wbsel;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic            ex_valid;
  logic            stall;
  logic            flush_if_id;

  modport master (
    output id_opcode, id_funct3, id_alu_select, id_reg_write_en, id_bsel, id_asel,
           id_dm_write_en, id_wbsel, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, pc_sel_ex,
    input  ex_opcode, ex_funct3, ex_alu_select, ex_reg_write_en, ex_bsel, ex_asel,
           ex_dm_write_en, ex_wbsel, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_valid, stall, flush_if_id
  );

  modport slave (
    input  id_opcode, id_funct3, id_alu_select, id_reg_write_en, id_bsel, id_asel,
           id_dm_write_en, id_wbsel, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, pc_sel_ex,
    output ex_opcode, ex_funct3, ex_alu_select, ex_reg_write_en, ex_bsel, ex_asel,
           ex_dm_write_en, ex_wbsel, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_valid, stall, flush_if_id
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard: a valid load in EX writes a register the ID instruction actually reads.
// Purely combinational, no state.
module hazard_detect
  import rv_pkg::*;
(
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [6:0] ex_opcode,
  input  logic [4:0] ex_rd,
  input  logic       ex_valid,
  output logic       hazard
);

  logic load_in_ex;
  logic rs1_dep;
  logic rs2_dep;

  assign load_in_ex = ex_valid && (ex_opcode == OP_LOAD) && (ex_rd != 5'd0);
  assign rs1_dep    = uses_rs1(id_opcode) && (ex_rd == id_rs1);
  assign rs2_dep    = uses_rs2(id_opcode) && (ex_rd == id_rs2);
  assign hazard     = load_in_ex && (rs1_dep || rs2_dep);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register, 1-cycle latency; bubbles on load-use hazard or taken branch/JALR, stall/flush_if_id combinational.
// PERF_CNT_EN adds saturating stall_cnt/flush_cnt.
module id_ex_stage
  import rv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`endif
);

  stage_t id_word;
  stage_t ex_q;
  logic   hazard;
  logic   stall_w;

  hazard_detect u_hazard (
    .id_opcode (bus.id_opcode),
    .id_rs1    (bus.id_rs1),
    .id_rs2    (bus.id_rs2),
    .ex_opcode (ex_q.opcode),
    .ex_rd     (ex_q.rd),
    .ex_valid  (ex_q.valid),
    .hazard    (hazard)
  );

  always_comb begin
    id_word                   = BUBBLE_STAGE;
    id_word.opcode            = bus.id_opcode;
    id_word.funct3            = bus.id_funct3;
    id_word.ctrl.alu_select   = bus.id_alu_select;
    id_word.ctrl.reg_write_en = bus.id_reg_write_en;
    id_word.ctrl.bsel         = bus.id_bsel;
    id_word.ctrl.asel         = bus.id_asel;
    id_word.ctrl.dm_write_en  = bus.id_dm_write_en;
    id_word.ctrl.wbsel        = bus.id_wbsel;
    id_word.pc                = bus.id_pc;
    id_word.rs1_data          = bus.id_rs1_data;
    id_word.rs2_data          = bus.id_rs2_data;
    id_word.imm               = bus.id_imm;
    id_word.rs1               = bus.id_rs1;
    id_word.rs2               = bus.id_rs2;
    id_word.rd                = bus.id_rd;
    id_word.valid             = 1'b1;
  end

  // A taken branch squashes the ID instruction anyway, so it must not also hold the PC.
  assign stall_w = hazard && !bus.pc_sel_ex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= BUBBLE_STAGE;
    end else if (bus.pc_sel_ex || hazard) begin
      ex_q <= BUBBLE_STAGE;
    end else begin
      ex_q <= id_word;
    end
  end

  assign bus.stall           = stall_w;
  assign bus.flush_if_id     = bus.pc_sel_ex;
  assign bus.ex_opcode       = ex_q.opcode;
  assign bus.ex_funct3       = ex_q.funct3;
  assign bus.ex_alu_select   = ex_q.ctrl.alu_select;
  assign bus.ex_reg_write_en = ex_q.ctrl.reg_write_en;
  assign bus.ex_bsel         = ex_q.ctrl.bsel;
  assign bus.ex_asel         = ex_q.ctrl.asel;
  assign bus.ex_dm_write_en  = ex_q.ctrl.dm_write_en;
  assign bus.ex_wbsel        = ex_q.ctrl.wbsel;
  assign bus.ex_pc           = ex_q.pc;
  assign bus.ex_rs1_data     = ex_q.rs1_data;
  assign bus.ex_rs2_data     = ex_q.rs2_data;
  assign bus.ex_imm          = ex_q.imm;
  assign bus.ex_rs1          = ex_q.rs1;
  assign bus.ex_rs2          = ex_q.rs2;
  assign bus.ex_rd           = ex_q.rd;
  assign bus.ex_valid        = ex_q.valid;

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_w && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (bus.pc_sel_ex && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/reset scenarios then random instruction streams vs a reference model.
module tb_id_ex_stage;
  import rv_pkg::*;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        rwe;
    logic        bsel;
    logic        asel;
    logic        dmwe;
    logic [1:0]  wbsel;
    logic [31:0] pc;
    logic [31:0] r1d;
    logic [31:0] r2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        valid;
  } exp_t;

  localparam logic [6:0] RS1_OPS [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                         7'b0100011, 7'b1100011, 7'b1100111};
  localparam logic [6:0] RS2_OPS [3] = '{7'b0110011, 7'b0100011, 7'b1100011};
  localparam logic [6:0] RAND_OPS [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                          7'b1100011, 7'b1100111, 7'b0110111, 7'b1101111};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  exp_t        m;
  logic [31:0] m_scnt;
  logic [31:0] m_fcnt;
  logic        obs_stall;
  logic        obs_flush;

  id_ex_stage_if bus();
`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  id_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t dut_word();
    return '{bus.ex_opcode, bus.ex_funct3, bus.ex_alu_select, bus.ex_reg_write_en,
             bus.ex_bsel, bus.ex_asel, bus.ex_dm_write_en, bus.ex_wbsel, bus.ex_pc,
             bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm, bus.ex_rs1, bus.ex_rs2,
             bus.ex_rd, bus.ex_valid};
  endfunction

  function automatic exp_t id_word();
    return '{bus.id_opcode, bus.id_funct3, bus.id_alu_select, bus.id_reg_write_en,
             bus.id_bsel, bus.id_asel, bus.id_dm_write_en, bus.id_wbsel, bus.id_pc,
             bus.id_rs1_data, bus.id_rs2_data, bus.id_imm, bus.id_rs1, bus.id_rs2,
             bus.id_rd, 1'b1};
  endfunction

  function automatic logic model_hazard();
    logic r1 = 1'b0;
    logic r2 = 1'b0;
    foreach (RS1_OPS[i]) if (bus.id_opcode == RS1_OPS[i]) r1 = 1'b1;
    foreach (RS2_OPS[i]) if (bus.id_opcode == RS2_OPS[i]) r2 = 1'b1;
    return m.valid && (m.op == 7'b0000011) && (m.rd != 5'd0) &&
           ((r1 && m.rd == bus.id_rs1) || (r2 && m.rd == bus.id_rs2));
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic ps);
    bus.id_opcode       = op;
    bus.id_funct3       = 3'($urandom);
    bus.id_alu_select   = 4'($urandom);
    bus.id_reg_write_en = 1'($urandom);
    bus.id_bsel         = 1'($urandom);
    bus.id_asel         = 1'($urandom);
    bus.id_dm_write_en  = 1'($urandom);
    bus.id_wbsel        = 2'($urandom);
    bus.id_pc           = $urandom;
    bus.id_rs1_data     = $urandom;
    bus.id_rs2_data     = $urandom;
    bus.id_imm          = $urandom;
    bus.id_rs1          = rs1;
    bus.id_rs2          = rs2;
    bus.id_rd           = rd;
    bus.pc_sel_ex       = ps;
  endtask

  // One clock: check combinational outputs before the edge, then registered state after it.
  task automatic step();
    logic hz;
    logic ps;
    #2;
    hz = model_hazard();
    ps = bus.pc_sel_ex;
    obs_stall = bus.stall;
    obs_flush = bus.flush_if_id;
    chk("stall", obs_stall, hz & ~ps);
    chk("flush_if_id", obs_flush, ps);
    @(posedge clk);
    if (hz && !ps && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
    if (ps && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
    m = (ps || hz) ? exp_t'(0) : id_word();
    #1;
    chk("ex_word", dut_word(), m);
`ifdef PERF_CNT_EN
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", flush_cnt, m_fcnt);
`endif
  endtask

  task automatic do_reset();
    bus.pc_sel_ex = 1'b0;
    rst_n = 1'b0;
    #1;
    m = '0;
    m_scnt = '0;
    m_fcnt = '0;
    chk("rst_ex_word", dut_word(), m);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_flush", bus.flush_if_id, 1'b0);
`ifdef PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] fl_before;
    logic [31:0] st_before;
    m = '0;
    m_scnt = '0;
    m_fcnt = '0;
    set_instr(OP_I, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    do_reset();

    // addi after reset is captured
    set_instr(OP_I, 5'd1, 5'd0, 5'd0, 1'b0);
    step();
    chk("first_valid", bus.ex_valid, 1'b1);

    // lw x5,0(x1) ; add x6,x5,x2
    set_instr(OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0);
    step();
    set_instr(OP_R, 5'd6, 5'd5, 5'd2, 1'b0);
    step();
    chk("lu_stall", obs_stall, 1'b1);
    chk("lu_bubble", bus.ex_valid, 1'b0);
    step();
    chk("lu_stall_clear", obs_stall, 1'b0);
    chk("lu_ex_rs1", bus.ex_rs1, 5'd5);
    chk("lu_valid", bus.ex_valid, 1'b1);

    // load to x0 never stalls
    set_instr(OP_LOAD, 5'd0, 5'd1, 5'd0, 1'b0);
    step();
    set_instr(OP_R, 5'd6, 5'd0, 5'd2, 1'b0);
    step();
    chk("x0_stall", obs_stall, 1'b0);

    // store depends on rs2, addi does not
    set_instr(OP_LOAD, 5'd7, 5'd1, 5'd0, 1'b0);
    step();
    set_instr(OP_STORE, 5'd0, 5'd3, 5'd7, 1'b0);
    step();
    chk("sw_stall", obs_stall, 1'b1);
    step();
    set_instr(OP_LOAD, 5'd7, 5'd1, 5'd0, 1'b0);
    step();
    set_instr(OP_I, 5'd8, 5'd9, 5'd7, 1'b0);
    step();
    chk("addi_stall", obs_stall, 1'b0);

    // flush and hazard together
    set_instr(OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0);
    step();
    fl_before = m_fcnt;
    st_before = m_scnt;
    set_instr(OP_R, 5'd6, 5'd5, 5'd2, 1'b1);
    step();
    chk("sim_stall", obs_stall, 1'b0);
    chk("sim_flush", obs_flush, 1'b1);
    chk("sim_bubble_op", bus.ex_opcode, 7'd0);
`ifdef PERF_CNT_EN
    chk("sim_flush_cnt", flush_cnt, fl_before + 32'd1);
    chk("sim_stall_cnt", stall_cnt, st_before);
`endif

    // reset while a load sits in EX; first capture afterwards is unconditional
    set_instr(OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0);
    step();
    do_reset();
    set_instr(OP_R, 5'd6, 5'd5, 5'd2, 1'b0);
    step();
    chk("post_rst_stall", obs_stall, 1'b0);
    chk("post_rst_valid", bus.ex_valid, 1'b1);

    for (int i = 0; i < 400; i++) begin
      set_instr(RAND_OPS[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0));
      step();
    end

`ifdef PERF_CNT_EN
    // saturation
    set_instr(OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0);
    step();
    set_instr(OP_R, 5'd6, 5'd5, 5'd2, 1'b0);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    m_scnt = 32'hFFFF_FFFE;
    step();
    chk("sat_reach", stall_cnt, 32'hFFFF_FFFF);
    set_instr(OP_LOAD, 5'd5, 5'd1, 5'd0, 1'b0);
    step();
    set_instr(OP_R, 5'd6, 5'd5, 5'd2, 1'b0);
    step();
    chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
